// File: rtl/grid_clb_param_if.sv
// Bus bundle for the parametrised CLB tile: cluster inputs, config chain, outputs.
interface grid_clb_param_if #(
    parameter int I = 12,
    parameter int N = 4
);
    logic [I-1:0] clb_I;
    logic         ccff_en;
    logic         ccff_head;
    logic         ccff_tail;
    logic [N-1:0] clb_O;
    logic         cfg_valid;

    modport master (
        output clb_I, ccff_en, ccff_head,
        input  ccff_tail, clb_O, cfg_valid
    );

    modport slave (
        input  clb_I, ccff_en, ccff_head,
        output ccff_tail, clb_O, cfg_valid
    );
endinterface

// File: rtl/grid_clb_param.sv
// Parametrised CLB tile: N BLEs of K-input LUT + optional FF, crossbar input
// selection over cluster inputs and FF feedback, serial configuration chain.
module grid_clb_param #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int I = 12
) (
    input logic             clk,
    input logic             reset,
    grid_clb_param_if.slave bus
);
    localparam int S        = $clog2(I + N);
    localparam int L        = 2 ** K;
    localparam int B        = L + K * S + 2;
    localparam int CFG_BITS = N * B;
    localparam int CW       = $clog2(CFG_BITS + 1);
    localparam logic [CW-1:0] CFG_FULL = CW'(CFG_BITS);

    logic [CFG_BITS-1:0] cfg;
    logic [CW-1:0]       count;
    logic                ccff_en_d;
    logic                cfg_valid;
    logic [N-1:0]        ff;
    logic [N-1:0]        lut_out;
    logic [N-1:0]        bypass;
    logic [N-1:0]        init;
    logic [2**S-1:0]     src;
    logic [S-1:0]        sel;
    logic [K-1:0]        idx;
    logic [L-1:0]        truth;

    // Crossbar and LUT evaluation for every BLE; selects beyond I+N read the zero padding.
    always_comb begin
        src            = '0;
        src[I+N-1:0]   = {ff, bus.clb_I};
        lut_out        = '0;
        bypass         = '0;
        init           = '0;
        sel            = '0;
        idx            = '0;
        truth          = '0;
        for (int unsigned j = 0; j < N; j++) begin
            truth = cfg[j*B +: L];
            idx   = '0;
            for (int unsigned k = 0; k < K; k++) begin
                sel    = cfg[j*B + L + k*S +: S];
                idx[k] = src[sel];
            end
            lut_out[j] = truth[idx];
            bypass[j]  = cfg[j*B + L + K*S];
            init[j]    = cfg[j*B + L + K*S + 1];
        end
    end

    // Configuration shift register, new bit enters at the bottom.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg <= '0;
        end else if (bus.ccff_en) begin
            cfg <= {cfg[CFG_BITS-2:0], bus.ccff_head};
        end
    end

    // Load counter: restarts on a rising enable, saturates at a full chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            ccff_en_d <= 1'b0;
        end else begin
            ccff_en_d <= bus.ccff_en;
            if (bus.ccff_en) begin
                if (!ccff_en_d) begin
                    count <= CW'(1);
                end else if (count != CFG_FULL) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    // Outputs go live only after a complete load has finished shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_valid <= 1'b0;
        end else if (bus.ccff_en) begin
            cfg_valid <= 1'b0;
        end else if (count == CFG_FULL) begin
            cfg_valid <= 1'b1;
        end
    end

    // BLE flip-flops hold their init value until the tile is live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else if (bus.ccff_en || !cfg_valid) begin
            ff <= init;
        end else begin
            ff <= lut_out;
        end
    end

    assign bus.ccff_tail = cfg[CFG_BITS-1];
    assign bus.cfg_valid = cfg_valid;
    assign bus.clb_O     = cfg_valid ? ((bypass & lut_out) | (~bypass & ff)) : '0;

endmodule

// File: tb/tb_grid_clb_param.sv
// Bench for grid_clb_param: randomized stimulus against a behavioural tile model.
module tb_grid_clb_param;
    localparam int N        = 4;
    localparam int K        = 4;
    localparam int I        = 12;
    localparam int S        = 4;
    localparam int L        = 16;
    localparam int B        = 34;
    localparam int CFG_BITS = 136;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    grid_clb_param_if #(.I(I), .N(N)) bus ();

    grid_clb_param #(.N(N), .K(K), .I(I)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: configuration image, bits shifted in the current
    // enable run, live flag and BLE register contents.
    bit mcfg [CFG_BITS];
    int run;
    bit men_prev;
    bit mvalid;
    bit mff [N];

    function automatic int fld(input int base, input int w);
        int v = 0;
        for (int i = 0; i < w; i++)
            if (mcfg[base + i]) v += (1 << i);
        return v;
    endfunction

    function automatic bit mlut(input int j);
        int idx = 0;
        for (int k = 0; k < K; k++) begin
            int s = fld(j*B + L + k*S, S);
            bit v = 1'b0;
            if (s < I) v = bus.clb_I[s];
            else if (s < I + N) v = mff[s - I];
            if (v) idx += (1 << k);
        end
        return mcfg[j*B + idx];
    endfunction

    function automatic logic [N-1:0] mout();
        logic [N-1:0] o = '0;
        for (int j = 0; j < N; j++)
            if (mvalid) o[j] = mcfg[j*B + L + K*S] ? mlut(j) : mff[j];
        return o;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CFG_BITS; i++) mcfg[i] = 1'b0;
        for (int j = 0; j < N; j++) mff[j] = 1'b0;
        run = 0; men_prev = 1'b0; mvalid = 1'b0;
    endtask

    task automatic model_edge();
        bit nff [N];
        for (int j = 0; j < N; j++)
            nff[j] = (bus.ccff_en || !mvalid) ? mcfg[j*B + L + K*S + 1] : mlut(j);
        for (int j = 0; j < N; j++) mff[j] = nff[j];
        if (bus.ccff_en) begin
            run    = men_prev ? run + 1 : 1;
            mvalid = 1'b0;
            for (int i = CFG_BITS - 1; i > 0; i--) mcfg[i] = mcfg[i-1];
            mcfg[0] = bus.ccff_head;
        end else if (run >= CFG_BITS) begin
            mvalid = 1'b1;
        end
        men_prev = bus.ccff_en;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic shift_image(input logic [CFG_BITS-1:0] img);
        bus.ccff_en = 1'b1;
        for (int i = CFG_BITS - 1; i >= 0; i--) begin
            bus.ccff_head = img[i];
            tick();
        end
    endtask

    task automatic end_load();
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
        tick();
    endtask

    function automatic logic [CFG_BITS-1:0] and_image();
        logic [CFG_BITS-1:0] img = '0;
        img[0 +: L]     = 16'h8888;
        img[L + S +: S] = 4'd1;
        img[L + K*S]    = 1'b1;
        return img;
    endfunction

    task automatic test_reset();
        logic [CFG_BITS-1:0] img = '1;
        shift_image(img);
        end_load();
        if (bus.clb_O !== 4'hF) begin errors++; $display("FAIL reset_preload clb_O got %h want %h", bus.clb_O, 4'hF); end
        checks++;
        #3 reset = 1'b1;
        model_clear();
        #1;
        if ({bus.clb_O, bus.ccff_tail, bus.cfg_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async clb_O/tail/valid got %h/%b/%b want 0/0/0", bus.clb_O, bus.ccff_tail, bus.cfg_valid);
        end
        checks++;
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.clb_I = I'($urandom);
            tick();
            if ({bus.clb_O, bus.ccff_tail, bus.cfg_valid} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold clb_O/tail/valid got %h/%b/%b want 0/0/0", bus.clb_O, bus.ccff_tail, bus.cfg_valid);
            end
            checks++;
        end
    endtask

    task automatic test_chain();
        bit hist [$];
        bit exp_tail;
        bus.ccff_en = 1'b1;
        for (int n = 0; n < 2 * CFG_BITS; n++) begin
            bus.ccff_head = 1'($urandom);
            hist.push_back(bus.ccff_head);
            tick();
            exp_tail = (n >= CFG_BITS - 1) ? hist[n - (CFG_BITS - 1)] : 1'b0;
            if (bus.ccff_tail !== exp_tail || bus.cfg_valid !== 1'b0) begin
                errors++;
                $display("FAIL chain_tail shift %0d tail/valid got %b/%b want %b/0", n, bus.ccff_tail, bus.cfg_valid, exp_tail);
            end
            checks++;
        end
        end_load();
        if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL chain_valid got %b want 1", bus.cfg_valid); end
        checks++;
        for (int c = 0; c < 12; c++) begin
            bus.clb_I = I'($urandom);
            #1;
            if (bus.clb_O !== mout()) begin errors++; $display("FAIL chain_random_comb clb_O got %h want %h", bus.clb_O, mout()); end
            checks++;
            tick();
            if (bus.clb_O !== mout()) begin errors++; $display("FAIL chain_random_edge clb_O got %h want %h", bus.clb_O, mout()); end
            checks++;
        end
    endtask

    task automatic test_comb_and();
        logic [1:0] pats [4] = '{2'b11, 2'b01, 2'b10, 2'b11};
        logic       expv;
        shift_image(and_image());
        end_load();
        for (int p = 0; p < 4; p++) begin
            bus.clb_I = {10'($urandom), pats[p]};
            expv = (pats[p] == 2'b11);
            #1;
            if (bus.clb_O[0] !== expv || bus.clb_O !== mout()) begin
                errors++;
                $display("FAIL comb_and in %b clb_O got %h want bit0=%b model %h", pats[p], bus.clb_O, expv, mout());
            end
            checks++;
        end
    endtask

    task automatic test_toggle();
        logic [CFG_BITS-1:0] img = '0;
        logic                seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        img[B +: L]     = 16'h5555;
        img[B + L +: S] = 4'd13;
        shift_image(img);
        end_load();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                bus.clb_I = I'($urandom);
                tick();
            end
            if (bus.clb_O[1] !== seq[c] || bus.clb_O !== mout()) begin
                errors++;
                $display("FAIL toggle step %0d clb_O got %h want bit1=%b model %h", c, bus.clb_O, seq[c], mout());
            end
            checks++;
        end
        bus.ccff_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.ccff_head = 1'($urandom);
            tick();
            if (bus.cfg_valid !== 1'b0 || bus.clb_O !== 4'h0) begin
                errors++;
                $display("FAIL reconfig_drop cycle %0d valid/clb_O got %b/%h want 0/0", c, bus.cfg_valid, bus.clb_O);
            end
            checks++;
        end
        end_load();
        if (bus.cfg_valid !== 1'b0 || bus.clb_O !== 4'h0) begin
            errors++;
            $display("FAIL reconfig_short valid/clb_O got %b/%h want 0/0", bus.cfg_valid, bus.clb_O);
        end
        checks++;
    endtask

    task automatic test_partial_overlong();
        bus.ccff_en = 1'b1;
        for (int n = 0; n < CFG_BITS - 1; n++) begin
            bus.ccff_head = 1'($urandom);
            tick();
        end
        end_load();
        for (int c = 0; c < 3; c++) begin
            bus.clb_I = I'($urandom);
            tick();
            if (bus.cfg_valid !== 1'b0 || bus.clb_O !== 4'h0) begin
                errors++;
                $display("FAIL partial valid/clb_O got %b/%h want 0/0", bus.cfg_valid, bus.clb_O);
            end
            checks++;
        end
        bus.ccff_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus.ccff_head = 1'($urandom);
            tick();
        end
        shift_image(and_image());
        end_load();
        if (bus.cfg_valid !== 1'b1) begin errors++; $display("FAIL overlong_valid got %b want 1", bus.cfg_valid); end
        checks++;
        bus.clb_I = {10'($urandom), 2'b11};
        #1;
        if (bus.clb_O !== 4'b0001 || bus.clb_O !== mout()) begin
            errors++;
            $display("FAIL overlong_and11 clb_O got %h want %h", bus.clb_O, 4'b0001);
        end
        checks++;
        bus.clb_I = {10'($urandom), 2'b01};
        #1;
        if (bus.clb_O !== 4'b0000) begin errors++; $display("FAIL overlong_and01 clb_O got %h want %h", bus.clb_O, 4'b0000); end
        checks++;
    endtask

    task automatic test_reset_midshift();
        bus.ccff_en = 1'b1;
        for (int n = 0; n < 50; n++) begin
            bus.ccff_head = 1'($urandom);
            tick();
        end
        #3 reset = 1'b1;
        model_clear();
        #1;
        if (bus.cfg_valid !== 1'b0 || bus.ccff_tail !== 1'b0 || bus.clb_O !== 4'h0) begin
            errors++;
            $display("FAIL midshift_reset valid/tail/clb_O got %b/%b/%h want 0/0/0", bus.cfg_valid, bus.ccff_tail, bus.clb_O);
        end
        checks++;
        #1 reset = 1'b0;
        for (int n = 0; n < CFG_BITS - 1; n++) begin
            bus.ccff_head = 1'($urandom);
            tick();
        end
        end_load();
        if (bus.cfg_valid !== 1'b0) begin errors++; $display("FAIL midshift_short valid got %b want 0", bus.cfg_valid); end
        checks++;
        shift_image(and_image());
        end_load();
        bus.clb_I = {10'($urandom), 2'b11};
        #1;
        if (bus.cfg_valid !== 1'b1 || bus.clb_O !== 4'b0001) begin
            errors++;
            $display("FAIL midshift_reload valid/clb_O got %b/%h want 1/1", bus.cfg_valid, bus.clb_O);
        end
        checks++;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        clk           = 1'b0;
        reset         = 1'b1;
        bus.clb_I     = '0;
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
        model_clear();
        #8 reset = 1'b0;
        tick();
        test_reset();
        test_chain();
        test_comb_and();
        test_toggle();
        test_partial_overlong();
        test_reset_midshift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
